// File: rtl/calc_alu_arbiter.sv
// calc_alu_arbiter: round-robin arbiter sharing one multi-cycle ALU between two requesters.
// Define CALC_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT cycles without alu_done.
module calc_alu_arbiter #(
   parameter int DATA_W  = 16,
   parameter int OP_W    = 4,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [OP_W-1:0]   req0_op,
   output logic              req0_ready,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_result,
   output logic              rsp0_err,
   input  logic              req1_valid,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [OP_W-1:0]   req1_op,
   output logic              req1_ready,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_result,
   output logic              rsp1_err,
   output logic              alu_start,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [OP_W-1:0]   alu_op,
   input  logic              alu_done,
   input  logic [DATA_W-1:0] alu_result,
   output logic              busy,
   output logic              grant_id
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t            state_q, state_d;
   logic              prio_q, prio_d;
   logic              grant_q, grant_d;
   logic              start_q, start_d;
   logic              v0_q, v0_d, v1_q, v1_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
   logic [DATA_W-1:0] res0_q, res0_d, res1_q, res1_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic              acc, win1, fin, timeout_hit;
   logic [DATA_W-1:0] res_in;

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("TIMEOUT must be at least 1");
   end

   // On a tie prio_q names the requester that was not served last.
   assign win1 = req1_valid & (~req0_valid | prio_q);
   assign acc = (state_q == IDLE) & (req0_valid | req1_valid);
   assign req0_ready = ~rst & acc & ~win1;
   assign req1_ready = ~rst & acc & win1;
   assign fin = alu_done | timeout_hit;
   assign res_in = alu_done ? alu_result : '0;

`ifdef CALC_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          e0_q, e0_d, e1_q, e1_d;
   assign timeout_hit = (state_q == WAIT) & (cnt_q == CW'(TIMEOUT - 1));
   // Counter idles at zero outside WAIT, so it is already clear on WAIT entry.
   always_comb begin
      cnt_d = (state_q == WAIT) ? cnt_q + 1'b1 : '0;
      e0_d = timeout_hit & ~alu_done & ~grant_q;
      e1_d = timeout_hit & ~alu_done & grant_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         e0_q <= 1'b0;
         e1_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         e0_q <= e0_d;
         e1_q <= e1_d;
      end
   end
   assign rsp0_err = e0_q;
   assign rsp1_err = e1_q;
`else
   assign timeout_hit = 1'b0;
   assign rsp0_err = 1'b0;
   assign rsp1_err = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      prio_d = prio_q;
      grant_d = grant_q;
      start_d = 1'b0;
      v0_d = 1'b0;
      v1_d = 1'b0;
      a_d = a_q;
      b_d = b_q;
      op_d = op_q;
      res0_d = res0_q;
      res1_d = res1_q;
      case (state_q)
         IDLE: if (acc) begin
            state_d = ISSUE;
            grant_d = win1;
            start_d = 1'b1;
            a_d = win1 ? req1_a : req0_a;
            b_d = win1 ? req1_b : req0_b;
            op_d = win1 ? req1_op : req0_op;
         end
         ISSUE: state_d = WAIT;
         WAIT: if (fin) begin
            state_d = RESP;
            v0_d = ~grant_q;
            v1_d = grant_q;
            res0_d = grant_q ? res0_q : res_in;
            res1_d = grant_q ? res_in : res1_q;
         end
         default: begin
            state_d = IDLE;
            prio_d = ~grant_q;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         prio_q <= 1'b0;
         grant_q <= 1'b0;
         start_q <= 1'b0;
         v0_q <= 1'b0;
         v1_q <= 1'b0;
         a_q <= '0;
         b_q <= '0;
         op_q <= '0;
         res0_q <= '0;
         res1_q <= '0;
      end else begin
         state_q <= state_d;
         prio_q <= prio_d;
         grant_q <= grant_d;
         start_q <= start_d;
         v0_q <= v0_d;
         v1_q <= v1_d;
         a_q <= a_d;
         b_q <= b_d;
         op_q <= op_d;
         res0_q <= res0_d;
         res1_q <= res1_d;
      end
   end

   assign busy = state_q != IDLE;
   assign grant_id = grant_q;
   assign alu_start = start_q;
   assign alu_a = a_q;
   assign alu_b = b_q;
   assign alu_op = op_q;
   assign rsp0_valid = v0_q;
   assign rsp1_valid = v1_q;
   assign rsp0_result = res0_q;
   assign rsp1_result = res1_q;
endmodule

// File: doc/calc_alu_arbiter.md
CALC_ALU_ARBITER -- requirements
Module: calc_alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, operand and result width.
REQ-002 SHALL have parameter OP_W, default 4, operation-code width.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum WAIT cycles before abort (used only with CALC_TIMEOUT_EN).
REQ-004 SHALL use one clock and an asynchronous, active-high reset. Ports are clk (in, 1, rising-edge clock) and rst (in, 1, asynchronous active-high reset).
REQ-005 SHALL have the following requester-0 (PS2 keypad) ports:
- req0_valid  in  1  request pending.
- req0_a  in  DATA_W  operand A.
- req0_b  in  DATA_W  operand B.
- req0_op  in  OP_W  operation code.
- req0_ready  out  1  request accepted this cycle.
- rsp0_valid  out  1  one-cycle response strobe.
- rsp0_result  out  DATA_W  result.
- rsp0_err  out  1  aborted.
REQ-006 SHALL have requester-1 (Avalon host) ports req1_valid, req1_a, req1_b, req1_op, req1_ready, rsp1_valid, rsp1_result and rsp1_err, identical in direction, width and meaning to their requester-0 counterparts.
REQ-007 SHALL have the following ALU-side and status ports:
- alu_start  out  1  one-cycle start pulse.
- alu_a  out  DATA_W  ALU operand A.
- alu_b  out  DATA_W  ALU operand B.
- alu_op  out  OP_W  ALU operation code.
- alu_done  in  1  ALU completion strobe.
- alu_result  in  DATA_W  ALU result.
- busy  out  1  state != IDLE.
- grant_id  out  1  current/last granted requester.

Function
REQ-008 SHALL implement a four-state FSM: IDLE, ISSUE, WAIT, RESP.
REQ-009 SHALL, in IDLE, combinationally assert reqN_ready for exactly one winner when any reqN_valid=1. Transfer occurs on valid&&ready: latch a/b/op into internal registers, set grant_id=N, and move to ISSUE.
REQ-010 SHALL arbitrate round-robin: when both valid in the same cycle, the winner is the requester NOT granted last; after reset, requester 0 wins a tie.
REQ-011 SHALL hold both reqN_ready=0 in every state other than IDLE.
REQ-012 SHALL, in ISSUE, drive alu_start=1 for exactly one cycle, then go to WAIT.
REQ-013 SHALL hold alu_a/alu_b/alu_op stable from ISSUE through RESP.
REQ-014 SHALL, in WAIT, capture alu_result on alu_done=1 and go to RESP.
REQ-015 SHALL ignore alu_done in IDLE, ISSUE and RESP, with no state change.
REQ-016 SHALL, in RESP, assert rspN_valid for one cycle only for N=grant_id, with rspN_result=captured result, update the round-robin pointer, and return to IDLE.
REQ-017 SHALL meet this latency: accept at cycle T, alu_start at T+1, alu_done at T+1+k (k>=1), rspN_valid at T+2+k. Back-to-back acceptance is possible at T+3+k.
REQ-018 SHALL hold rspN_result at its last value between strobes, and hold rspN_err at 0 except during an abort strobe.

Reset
REQ-019 SHALL, on rst=1 asynchronously:
- set state=IDLE.
- clear every output: ready, rsp_valid, rsp_result, rsp_err, alu_start, alu_a/b/op, busy and grant_id all 0.
- reset the round-robin pointer to favour requester 0.
- reset the timeout counter to 0.
REQ-020 SHALL discard any in-flight operation when reset is asserted mid-operation, with no response issued after rst deasserts, and SHALL ignore a late alu_done.

Configuration
REQ-021 SHALL, when CALC_TIMEOUT_EN is defined:
- clear a WAIT cycle counter on entry to WAIT.
- if it reaches TIMEOUT without alu_done, enter RESP with rspN_err=1 and rspN_result=0.
- give alu_done priority if it coincides with the terminal count.
REQ-022 SHALL, when CALC_TIMEOUT_EN is undefined, have no counter, wait indefinitely in WAIT, and tie rsp0_err/rsp1_err to 0.

Verification
REQ-023 Single request: req0 a=7 b=5 op=ADD, ALU done after 3 cycles with 12 -> req0_ready at T, alu_start at T+1, rsp0_valid=1 with result 12 at T+5, rsp1_valid never 1.
REQ-024 Tie: both valid from reset -> req0 served first; req1 held (ready=0) and served next; a following tie grants req0 again after req1.
REQ-025 Spurious done: alu_done pulsed while IDLE and during ISSUE -> no state change, no rsp strobe.
REQ-026 Reset mid-WAIT: rst for 1 cycle during WAIT, then alu_done -> busy=0, all outputs 0, no rsp strobe.
REQ-027 Timeout (CALC_TIMEOUT_EN, TIMEOUT=4): alu_done never asserted -> rsp1_valid=1, rsp1_err=1, rsp1_result=0 four cycles after WAIT entry. Without the macro: busy stays 1 and no response.
